// File: rtl/swap_sort_pkg.sv
// Shared constants and types for the swap-register-file bubble sort sequencer.
package swap_sort_pkg;
    localparam int N_REGS = 8;
    localparam int DW     = 4;
    localparam int IW     = $clog2(N_REGS);
    localparam int CW     = 5;

    typedef enum logic [1:0] {IDLE, INIT, SORT, DONE} state_t;
    typedef logic [DW-1:0] word_t;
    typedef logic [IW-1:0] idx_t;
endpackage

// File: rtl/pair_order_cmp.sv
// Adjacent-pair order check: flags a pair that must be swapped for the requested order.
module pair_order_cmp
    import swap_sort_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  logic  desc,
    output logic  out_of_order
);
    // strict compares: equal values never swap, keeping the sort stable
    assign out_of_order = desc ? (a < b) : (a > b);
endmodule

// File: rtl/swap_sort_sequencer.sv
// Bubble-sort sequencer driving the 8x4 swap register file in place.
// Optional SWAP_SORT_EARLY_EXIT_EN: finish as soon as a whole pass makes no swap.
module swap_sort_sequencer
    import swap_sort_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 start,
    input  logic                 order,
    input  logic [N_REGS*DW-1:0] r,
    output logic                 init,
    output logic                 swap,
    output logic [IW-1:0]        x,
    output logic [IW-1:0]        y,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        swap_cnt
);
    localparam idx_t LAST_J = idx_t'(N_REGS - 2);

    state_t        state_q, state_d;
    idx_t          pass_q, pass_d;
    idx_t          j_q, j_d;
    logic          ord_q, ord_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef SWAP_SORT_EARLY_EXIT_EN
    logic          ps_q, ps_d;
`endif

    logic [N_REGS-1:0][DW-1:0] r_arr;
    idx_t j_nxt;
    logic ooo;
    logic end_of_pass;

    assign r_arr       = r;
    assign j_nxt       = j_q + idx_t'(1);
    assign end_of_pass = (j_q == idx_t'(LAST_J - pass_q));

    pair_order_cmp u_cmp (
        .a            (r_arr[j_q]),
        .b            (r_arr[j_nxt]),
        .desc         (ord_q),
        .out_of_order (ooo)
    );

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        j_d     = j_q;
        ord_d   = ord_q;
        cnt_d   = cnt_q;
`ifdef SWAP_SORT_EARLY_EXIT_EN
        ps_d    = ps_q;
`endif
        init = 1'b0;
        swap = 1'b0;
        x    = '0;
        y    = '0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = INIT;
                end else if (start) begin
                    state_d = SORT;
                    ord_d   = order;
                    pass_d  = '0;
                    j_d     = '0;
                    cnt_d   = '0;
`ifdef SWAP_SORT_EARLY_EXIT_EN
                    ps_d    = 1'b0;
`endif
                end
            end
            INIT: begin
                init    = 1'b1;
                state_d = IDLE;
            end
            SORT: begin
                busy = 1'b1;
                x    = j_q;
                y    = j_nxt;
                swap = ooo;
                if (ooo) begin
                    if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
`ifdef SWAP_SORT_EARLY_EXIT_EN
                    ps_d = 1'b1;
`endif
                end
                if (end_of_pass) begin
`ifdef SWAP_SORT_EARLY_EXIT_EN
                    if (pass_q == LAST_J || !(ps_q || ooo)) begin
`else
                    if (pass_q == LAST_J) begin
`endif
                        state_d = DONE;
                    end else begin
                        pass_d = pass_q + idx_t'(1);
                        j_d    = '0;
`ifdef SWAP_SORT_EARLY_EXIT_EN
                        ps_d   = 1'b0;
`endif
                    end
                end else begin
                    j_d = j_nxt;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pass_q  <= '0;
            j_q     <= '0;
            ord_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SWAP_SORT_EARLY_EXIT_EN
            ps_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            j_q     <= j_d;
            ord_q   <= ord_d;
            cnt_q   <= cnt_d;
`ifdef SWAP_SORT_EARLY_EXIT_EN
            ps_q    <= ps_d;
`endif
        end
    end

    assign swap_cnt = cnt_q;
endmodule

// File: tb/tb_swap_sort_sequencer.sv
// Scoreboard bench: behavioural swap register file plus a software bubble-sort reference.
module tb_swap_sort_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0, start = 1'b0, order = 1'b0;
    logic [31:0] r_bus;
    logic        init, swap, busy, done;
    logic [2:0]  x, y;
    logic [4:0]  swap_cnt;

    logic [3:0]  rf [8];
    logic        pre_en = 1'b0;
    logic [31:0] pre_val = '0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] r;
        int          cnt;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    swap_sort_sequencer dut (
        .clk(clk), .reset_n(reset_n), .load(load), .start(start), .order(order),
        .r(r_bus), .init(init), .swap(swap), .x(x), .y(y),
        .busy(busy), .done(done), .swap_cnt(swap_cnt)
    );

    // register file model: not reset, so contents survive a sequencer reset
    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 8; i++) rf[i] <= pre_val[i*4 +: 4];
        end else if (init) begin
            for (int i = 0; i < 8; i++) rf[i] <= 4'(i);
        end else if (swap) begin
            rf[x] <= rf[y];
            rf[y] <= rf[x];
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) r_bus[i*4 +: 4] = rf[i];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_sort(input logic [31:0] in, input bit desc, input int limit,
                                     output logic [31:0] out, output int nsw, output int ncmp);
        logic [3:0] a [8];
        logic [3:0] t;
`ifdef SWAP_SORT_EARLY_EXIT_EN
        int pass_start;
`endif
        for (int i = 0; i < 8; i++) a[i] = in[i*4 +: 4];
        nsw  = 0;
        ncmp = 0;
        for (int p = 0; p < 7; p++) begin
`ifdef SWAP_SORT_EARLY_EXIT_EN
            pass_start = nsw;
`endif
            for (int j = 0; j < 7 - p; j++) begin
                if (ncmp < limit) begin
                    ncmp++;
                    if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
                        t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                        nsw++;
                    end
                end
            end
`ifdef SWAP_SORT_EARLY_EXIT_EN
            if (nsw == pass_start) break;
`endif
        end
        out = '0;
        for (int i = 0; i < 8; i++) out[i*4 +: 4] = a[i];
    endfunction

    // all tasks enter and leave on a falling edge
    task automatic do_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("load_init_hi", init, 1);
        chk("load_busy", busy, 0);
        chk("load_swap", swap, 0);
        @(negedge clk);
        chk("load_init_lo", init, 0);
        chk("load_r", r_bus, 32'h76543210);
    endtask

    task automatic preload(input logic [31:0] v);
        pre_val = v;
        pre_en  = 1'b1;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    task automatic run_sort(input bit desc, input int mid_start);
        exp_t e, g;
        int cyc, nsw;
        ref_sort(r_bus, desc, 1000, e.r, e.cnt, e.cyc);
        e.cyc = e.cyc + 1;
        sb.push_back(e);
        order = desc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        order = ~desc;
        cyc = 1;
        nsw = 0;
        while (!done && cyc < 100) begin
            if (swap) nsw++;
            start = (cyc == mid_start);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        g = sb.pop_front();
        chk("sort_cycles", cyc, g.cyc);
        chk("sort_swap_cnt", swap_cnt, g.cnt);
        chk("sort_r", r_bus, g.r);
        chk("sort_swaps_seen", nsw, g.cnt);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("cnt_hold", swap_cnt, g.cnt);
        chk("idle_busy", busy, 0);
    endtask

    task automatic run_reset(input bit desc, input int at);
        exp_t e, g;
        int nsw, ncmp, inits;
        ref_sort(r_bus, desc, at - 1, e.r, nsw, ncmp);
        e.cnt = 0;
        e.cyc = 0;
        sb.push_back(e);
        order = desc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (at - 1) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        g = sb.pop_front();
        chk("rst_busy", busy, 0);
        chk("rst_swap", swap, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_cnt", swap_cnt, g.cnt);
        chk("rst_init", init, 0);
        chk("rst_r", r_bus, g.r);
        inits = 0;
        repeat (3) begin
            @(negedge clk);
            if (init) inits++;
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (init) inits++;
        end
        chk("rst_no_init", inits, 0);
        chk("rst_r_kept", r_bus, g.r);
    endtask

    initial begin
        logic [31:0] v;
        repeat (2) @(negedge clk);
        chk("reset_init", init, 0);
        chk("reset_swap", swap, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_x", x, 0);
        chk("reset_y", y, 0);
        chk("reset_cnt", swap_cnt, 0);
        reset_n = 1'b1;
        @(negedge clk);

        do_load();
        run_sort(1'b1, 0);          // worst case: every compare swaps
        chk("desc_r", r_bus, 32'h01234567);

        do_load();
        run_sort(1'b0, 0);          // already sorted

        // load and start together: load wins, no sort begins
        load  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        chk("ls_init", init, 1);
        chk("ls_busy0", busy, 0);
        @(negedge clk);
        chk("ls_busy1", busy, 0);
        @(negedge clk);
        chk("ls_busy2", busy, 0);

        do_load();
        run_sort(1'b1, 5);          // start pulsed mid-sort is ignored

        for (int k = 0; k < 4; k++) begin
            v = '0;
            for (int i = 0; i < 8; i++) v[i*4 +: 4] = 4'($urandom_range(0, (k < 2) ? 3 : 15));
            preload(v);
            run_sort(k[0], 0);
        end

        preload(32'h3ffff333);      // many equal values
        run_sort(1'b0, 0);

        do_load();
        run_reset(1'b1, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/swap_sort_sequencer.md
Name: swap_sort_sequencer

Overview:
- Control stage directly upstream of the 8x4-bit swap register file; drives its init, swap, x and y inputs.
- Reads back the register file's r[7:0] bus and runs a bubble sort in place.
- Each compare is one adjacent-pair step; an out-of-order pair is swapped on the same clock edge.
- Also issues the one-cycle init pulse that reloads the register file with 0..7.

Parameters:
- N_REGS, 8, number of registers sorted; fixed at 8 to match the register file.
- DW, 4, data width of each register.
- IW, 3, index width, $clog2(N_REGS).
- CW, 5, swap counter width; holds the maximum 28 swaps.

Ports:
- clk  in  1  rising-edge clock, shared with the register file.
- reset_n  in  1  asynchronous active-low reset.
- load  in  1  in IDLE: issue one init pulse to the register file.
- start  in  1  in IDLE: begin sorting the current contents.
- order  in  1  0 = ascending, 1 = descending; sampled when start is accepted.
- r  in  [DW-1:0] x N_REGS  register file contents, r[0..7].
- init  out  1  to register file; reload pulse.
- swap  out  1  to register file; swap r[x] and r[y] at this edge.
- x  out  IW  to register file; first index.
- y  out  IW  to register file; second index.
- busy  out  1  high while in SORT.
- done  out  1  one-cycle pulse when a sort completes.
- swap_cnt  out  CW  swaps issued in the last or current sort.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - init, swap, busy, done, x, y and swap_cnt are all 0.
  - pass, j, ord_q and pass_swapped are cleared.
- States: IDLE, INIT, SORT, DONE.
- IDLE:
  - load=1 -> INIT; load has priority over start.
  - Otherwise start=1 -> SORT: ord_q<=order, pass<=0, j<=0, swap_cnt<=0, pass_swapped<=0.
- INIT: init=1 for exactly one cycle, then return to IDLE. Register file contents are 0..7 from the next cycle.
- SORT, every cycle:
  - x=j, y=j+1.
  - swap = ord_q ? (r[j] < r[j+1]) : (r[j] > r[j+1]), unsigned compare.
  - swap is combinational from the registered j/ord_q and the live r bus. r is updated at the same edge, so the next compare sees the swapped data with no wait cycle.
  - On swap: swap_cnt++ (saturating) and pass_swapped<=1.
- End of pass is when j == N_REGS-2-pass:
  - If pass == N_REGS-2 -> DONE.
  - Otherwise pass++, j<=0, pass_swapped<=0.
  - Otherwise (not end of pass) j++.
- Timing: the full sort is 7+6+5+4+3+2+1 = 28 SORT cycles, start accepted to done = 29 cycles.
- DONE: done=1 for one cycle, then IDLE. swap_cnt holds until the next accepted start.
- Outside SORT: swap=0, x=0, y=0.
- load/start while busy or in INIT/DONE are ignored and not queued.
- Reset mid-sort aborts to IDLE. The register file keeps its partially sorted contents; no init is issued.
- Equal values never swap, so the sort is stable.

Optional Feature:
- Macro: SWAP_SORT_EARLY_EXIT_EN.
- Defined:
  - At end of pass, if pass_swapped (including the current cycle's swap) is 0 -> DONE immediately.
  - An already-sorted input completes after 7 SORT cycles.
- Undefined: always runs all 28 compare cycles; pass_swapped logic is not built.

Decomposition:
- Package swap_sort_pkg holds:
  - constants N_REGS, DW, IW, CW;
  - typedef enum logic [1:0] state_t {IDLE, INIT, SORT, DONE};
  - typedef logic [DW-1:0] word_t;
  - typedef logic [IW-1:0] idx_t.
- One sub-module, pair_order_cmp (a, b, desc -> out_of_order), holds the compare. The FSM, counters and index muxing stay in the top module.

Test Plan:
- Reset, then load=1 for one cycle -> init high exactly one cycle; all other outputs 0; r reads 0..7.
- After load, start with order=1 -> 28 SORT cycles, every cycle swap=1, swap_cnt=28, r = 7,6,...,0, done pulse 29 cycles after start.
- After load, start with order=0:
  - EARLY_EXIT defined: done after 7 SORT cycles, swap_cnt=0.
  - EARLY_EXIT undefined: 28 cycles, swap_cnt=0.
- load and start high together in IDLE -> INIT taken, start ignored, busy stays 0.
- start pulsed mid-sort -> no restart, swap_cnt unaffected.
- reset_n low at SORT cycle 10 -> all outputs 0 immediately, busy low, r keeps its partially sorted values, no init pulse.
